// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 read-path types and encodings used by the
//                cache refill burst master.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

  // Read master control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } t_rd_state;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/axi_burst_read_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_read_master
//  Description : AXI4 INCR burst read master for cache-block refills. Issues
//                one block-aligned burst per start pulse and delivers the R
//                beats word by word with index, last flag and sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_read_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic                           i_start_read,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  output logic                           o_busy,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_data_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_word_index,
  output logic                           o_read_last,
  output logic                           o_resp_error,
  output logic                           o_ar_valid,
  input  logic                           i_ar_ready,
  output logic [ADDR_WIDTH-1:0]          o_ar_addr,
  output logic [7:0]                     o_ar_len,
  output logic [2:0]                     o_ar_size,
  output logic [1:0]                     o_ar_burst,
  input  logic                           i_r_valid,
  output logic                           o_r_ready,
  input  logic [DATA_WIDTH-1:0]          i_r_data,
  input  logic                           i_r_last,
  input  logic [1:0]                     i_r_resp
);

  localparam int IDX_W      = $clog2(BLOCK_WORDS);
  localparam int CNT_W      = IDX_W + 1;
  localparam int ALIGN_BITS = $clog2(BLOCK_WORDS * DATA_WIDTH / 8);

  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));

  t_rd_state               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    data_valid_q, data_valid_d;
  logic                    read_last_q, read_last_d;
  logic                    err_q, err_d;
  logic                    ar_valid_q, ar_valid_d;
  logic                    r_ready_q, r_ready_d;

  logic w_start_ok;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_last_beat;
  logic w_beat_err;

  // A start is only honoured once the previous burst has fully retired,
  // including the cycle that presents o_read_last.
  assign w_start_ok  = (state_q == IDLE) && i_start_read && !busy_q;
  assign w_ar_hs     = ar_valid_q && i_ar_ready;
  assign w_r_hs      = r_ready_q && i_r_valid;
  assign w_last_beat = (cnt_q == LAST_BEAT);
  // Bad response, early last, or missing last all flag the burst.
  assign w_beat_err  = (i_r_resp != AXI_RESP_OKAY) || (i_r_last != w_last_beat);

  // Next-state and next-output computation for the refill FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    err_d        = err_q;
    ar_valid_d   = ar_valid_q;
    r_ready_d    = r_ready_q;
    data_valid_d = 1'b0;
    read_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (w_start_ok) begin
          addr_d     = i_addr & ALIGN_MASK;
          cnt_d      = '0;
          err_d      = 1'b0;
          ar_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (w_ar_hs) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_r_hs) begin
          data_d       = i_r_data;
          idx_d        = cnt_q[IDX_W-1:0];
          data_valid_d = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
          if (w_beat_err) begin
            err_d = 1'b1;
          end
          // Termination is purely count based; r_last only feeds the error.
          if (w_last_beat) begin
            read_last_d = 1'b1;
            r_ready_d   = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      read_last_q  <= 1'b0;
      err_q        <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
      read_last_q  <= read_last_d;
      err_q        <= err_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_word_index = idx_q;
  assign o_read_last  = read_last_q;
  assign o_resp_error = err_q;
  assign o_ar_valid   = ar_valid_q;
  assign o_ar_addr    = addr_q;
  assign o_r_ready    = r_ready_q;

  // Fixed burst shape: one full block of full-width INCR beats
  assign o_ar_len   = 8'(BLOCK_WORDS - 1);
  assign o_ar_size  = 3'($clog2(DATA_WIDTH / 8));
  assign o_ar_burst = AXI_BURST_INCR;

endmodule : axi_burst_read_master
`default_nettype wire

// File: tb/tb_axi_burst_read_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_burst_read_master
//  Description : Scoreboard bench for the refill burst master. The stimulus
//                side queues the expected words of each burst; a monitor
//                pops and compares on every delivered word and AR handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_burst_read_master;
  import axi_pkg::*;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          arst;
  logic          i_start_read;
  logic [AW-1:0] i_addr;
  logic          o_busy;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic [3:0]    o_word_index;
  logic          o_read_last;
  logic          o_resp_error;
  logic          o_ar_valid;
  logic          i_ar_ready;
  logic [AW-1:0] o_ar_addr;
  logic [7:0]    o_ar_len;
  logic [2:0]    o_ar_size;
  logic [1:0]    o_ar_burst;
  logic          i_r_valid;
  logic          o_r_ready;
  logic [DW-1:0] i_r_data;
  logic          i_r_last;
  logic [1:0]    i_r_resp;

  axi_burst_read_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BLOCK_WORDS(BW)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .i_start_read (i_start_read),
    .i_addr       (i_addr),
    .o_busy       (o_busy),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_word_index (o_word_index),
    .o_read_last  (o_read_last),
    .o_resp_error (o_resp_error),
    .o_ar_valid   (o_ar_valid),
    .i_ar_ready   (i_ar_ready),
    .o_ar_addr    (o_ar_addr),
    .o_ar_len     (o_ar_len),
    .o_ar_size    (o_ar_size),
    .o_ar_burst   (o_ar_burst),
    .i_r_valid    (i_r_valid),
    .o_r_ready    (o_r_ready),
    .i_r_data     (i_r_data),
    .i_r_last     (i_r_last),
    .i_r_resp     (i_r_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          idx;
    logic        last;
    logic        err;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_b;
  logic [AW-1:0] exp_ar_addr = '0;
  int            ar_count = 0;
  int            last_cyc = 0;
  int            cyc = 0;
  int            burst_id = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] beat_data(input int id, input int k);
    return 32'hC0DE_0000 ^ (32'(id) << 8) ^ 32'(k);
  endfunction

  // Monitor: compares every AR handshake and every delivered word
  always @(negedge clk) begin
    if (o_ar_valid) begin
      chk("ar_addr", o_ar_addr, exp_ar_addr);
      if (i_ar_ready) begin
        ar_count++;
        chk("ar_len", 64'(o_ar_len), 64'd15);
        chk("ar_size", 64'(o_ar_size), 64'd2);
        chk("ar_burst", 64'(o_ar_burst), 64'd1);
      end
    end
    if (o_data_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_word");
      end else begin
        mon_b = exp_q.pop_front();
        chk("word_data", 64'(o_data), 64'(mon_b.data));
        chk("word_index", 64'(o_word_index), 64'(mon_b.idx));
        chk("read_last", 64'(o_read_last), 64'(mon_b.last));
        chk("resp_error", 64'(o_resp_error), 64'(mon_b.err));
        chk("busy_on_word", 64'(o_busy), 64'd1);
      end
      if (o_read_last) last_cyc = cyc;
    end else if (o_read_last) begin
      fail_now("read_last_without_valid");
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_data_valid"}, 64'(o_data_valid), 64'd0);
    chk({tag, "_read_last"}, 64'(o_read_last), 64'd0);
    chk({tag, "_resp_error"}, 64'(o_resp_error), 64'd0);
    chk({tag, "_ar_valid"}, 64'(o_ar_valid), 64'd0);
    chk({tag, "_r_ready"}, 64'(o_r_ready), 64'd0);
    chk({tag, "_data"}, 64'(o_data), 64'd0);
    chk({tag, "_word_index"}, 64'(o_word_index), 64'd0);
    chk({tag, "_ar_addr"}, o_ar_addr, 64'd0);
  endtask

  // Issues start, handles AR, returns with the bench just after the AR edge
  task automatic start_and_ar(input logic [AW-1:0] addr, input logic [AW-1:0] aligned,
                              input int ar_delay, output int start_cyc, output bit ok);
    bit hs;
    int n;
    exp_ar_addr  = aligned;
    i_start_read = 1'b1;
    i_addr       = addr;
    i_ar_ready   = (ar_delay == 0);
    start_cyc    = cyc;
    @(posedge clk); #1;
    i_start_read = 1'b0;
    i_addr       = '1;
    chk("err_clear_on_start", 64'(o_resp_error), 64'd0);
    chk("busy_after_start", 64'(o_busy), 64'd1);
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 60) begin
      i_ar_ready = (n >= ar_delay);
      @(negedge clk);
      hs = o_ar_valid && i_ar_ready;
      @(posedge clk); #1;
      n++;
    end
    i_ar_ready = 1'b0;
    ok = hs;
    if (!hs) fail_now("ar_handshake_timeout");
  endtask

  // Drives one R beat and waits (bounded) for its handshake
  task automatic drive_beat(input int k, input int slv_beat, input int last_pos, output bit ok);
    bit hs;
    int n;
    i_r_valid = 1'b1;
    i_r_data  = beat_data(burst_id, k);
    i_r_last  = (k == last_pos);
    i_r_resp  = (k == slv_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 60) begin
      @(negedge clk);
      hs = o_r_ready && i_r_valid;
      @(posedge clk); #1;
      n++;
    end
    ok = hs;
    if (!hs) fail_now("r_handshake_timeout");
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input int ar_delay, input bit gaps,
                           input int slv_beat, input int last_pos, input int poke_beat,
                           input int exp_latency);
    logic [AW-1:0] aligned;
    int first_err;
    int start_cyc;
    int ar_before;
    bit ok;
    burst_id++;
    aligned   = addr & ~64'h3F;
    first_err = 16;
    if (slv_beat < first_err) first_err = slv_beat;
    if (last_pos != 15) begin
      if (last_pos < 15 && last_pos < first_err) first_err = last_pos;
      else if (15 < first_err) first_err = 15;
    end
    for (int k = 0; k < BW; k++)
      exp_q.push_back('{data: beat_data(burst_id, k), idx: k, last: (k == BW - 1),
                        err: (k >= first_err)});
    ar_before = ar_count;
    start_and_ar(addr, aligned, ar_delay, start_cyc, ok);
    if (ok) begin
      for (int k = 0; k < BW; k++) begin
        if (gaps && k > 0) begin
          i_r_valid = 1'b0;
          @(posedge clk); #1;
        end
        i_start_read = (k == poke_beat);
        i_addr       = 64'hDEAD_BEEF_0000_0000;
        drive_beat(k, slv_beat, last_pos, ok);
        i_start_read = 1'b0;
        if (!ok) break;
      end
    end
    i_r_valid = 1'b0;
    i_r_last  = 1'b0;
    i_r_resp  = AXI_RESP_OKAY;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("words_outstanding", 64'(exp_q.size()), 64'd0);
    chk("ar_count", 64'(ar_count - ar_before), 64'd1);
    chk("busy_after_burst", 64'(o_busy), 64'd0);
    chk("sticky_error", 64'(o_resp_error), 64'(first_err < 16));
    if (exp_latency > 0) chk("latency", 64'(last_cyc - start_cyc), 64'(exp_latency));
    exp_q.delete();
  endtask

  // Asynchronous reset asserted while beat 5 is on the bus
  task automatic run_reset_abort(input logic [AW-1:0] addr);
    int start_cyc;
    bit ok;
    burst_id++;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{data: beat_data(burst_id, k), idx: k, last: 1'b0, err: 1'b0});
    start_and_ar(addr, addr & ~64'h3F, 0, start_cyc, ok);
    for (int k = 0; k < 5 && ok; k++) drive_beat(k, 99, 15, ok);
    i_r_valid = 1'b1;
    i_r_data  = beat_data(burst_id, 5);
    arst      = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) begin
      @(posedge clk); #1;
    end
    arst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("r_ready_after_reset", 64'(o_r_ready), 64'd0);
    i_r_valid = 1'b0;
    chk("abort_words_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    arst         = 1'b1;
    i_start_read = 1'b0;
    i_addr       = '0;
    i_ar_ready   = 1'b0;
    i_r_valid    = 1'b0;
    i_r_data     = '0;
    i_r_last     = 1'b0;
    i_r_resp     = AXI_RESP_OKAY;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    arst = 1'b0;
    @(posedge clk); #1;

    // zero-wait refill with latency check
    run_burst(64'h1000_0004, 0, 1'b0, 99, 15, 99, 18);
    // AR backpressure and R gaps
    run_burst(64'h2000_0ABC, 5, 1'b1, 99, 15, 99, 0);
    // SLVERR on beat 7
    run_burst(64'h3000_0040, 0, 1'b0, 7, 15, 99, 0);
    // error cleared by the next start
    run_burst(64'h3000_0080, 0, 1'b0, 99, 15, 99, 0);
    // early r_last on beat 3
    run_burst(64'h4000_0100, 0, 1'b0, 99, 3, 99, 0);
    // r_last never asserted
    run_burst(64'h4000_0200, 2, 1'b0, 99, 16, 99, 0);
    // start pulsed during DATA is ignored
    run_burst(64'h5000_0000, 0, 1'b0, 99, 15, 4, 0);
    // reset mid-burst, then a clean refill
    run_reset_abort(64'h6000_0000);
    run_burst(64'h6000_1234, 0, 1'b1, 99, 15, 99, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_axi_burst_read_master
`default_nettype wire

// File: doc/axi_burst_read_master.md
# axi_burst_read_master

AXI4 burst read master that performs cache-block refills for both the instruction and data caches. It accepts a single-cycle read request from the control unit's start-read strobe and issues one INCR burst on the AR channel. It collects the R beats and delivers them word by word to the cache fill path, signalling the final word on `o_read_last`, which drives the control unit's read-last input.

## Interface
Parameters:
- ADDR_WIDTH, 64, width of request and AR address
- DATA_WIDTH, 32, R data width and delivered word width
- BLOCK_WORDS, 16, beats per burst (power of two, 2..256)

Ports:
- clk  input  1  system clock
- arst  input  1  reset, asynchronous, active-high
- i_start_read  input  1  refill request pulse (control unit start-read)
- i_addr  input  ADDR_WIDTH  refill address, sampled with i_start_read
- o_busy  output  1  transaction in progress
- o_data  output  DATA_WIDTH  delivered word
- o_data_valid  output  1  o_data valid this cycle
- o_word_index  output  $clog2(BLOCK_WORDS)  word offset of o_data within the block
- o_read_last  output  1  final word of burst delivered this cycle
- o_resp_error  output  1  sticky error for the current/last burst
- o_ar_valid  output  1  AR valid
- i_ar_ready  input  1  AR ready
- o_ar_addr  output  ADDR_WIDTH  block-aligned burst address
- o_ar_len  output  8  constant BLOCK_WORDS-1
- o_ar_size  output  3  constant $clog2(DATA_WIDTH/8)
- o_ar_burst  output  2  constant INCR (2'b01)
- i_r_valid  input  1  R valid
- o_r_ready  output  1  R ready
- i_r_data  input  DATA_WIDTH  R data
- i_r_last  input  1  R last
- i_r_resp  input  2  R response

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: when i_start_read=1, capture i_addr with its low $clog2(BLOCK_WORDS*DATA_WIDTH/8) bits forced to 0. Clear o_resp_error and the beat counter. Go to ADDR.
- ADDR: o_ar_valid=1 and o_ar_addr=captured address, both held stable until i_ar_ready. On handshake, go to DATA.
- DATA: o_r_ready=1. On each R handshake:
  - register i_r_data into o_data and the counter value into o_word_index;
  - pulse o_data_valid;
  - increment the counter.
- Burst termination: the beat where the counter equals BLOCK_WORDS-1 is the last beat. After it, o_read_last pulses together with its o_data_valid, and the state returns to IDLE.
- Error conditions, all of which set o_resp_error (sticky until the next accepted start):
  - i_r_resp != OKAY (2'b00) on any beat;
  - i_r_last=1 on a beat other than the last;
  - i_r_last=0 on the last beat.
- Data from error beats is still delivered. Termination depends only on the beat count, never on i_r_last.
- i_start_read while o_busy=1 is ignored; no queuing.
- o_busy=1 in ADDR and DATA, and also in the cycle that carries o_read_last.
- Counter width is $clog2(BLOCK_WORDS)+1. The counter never wraps inside a burst.

## Timing
- All outputs are registered.
- Reset values: state IDLE; o_busy, o_data_valid, o_read_last, o_resp_error, o_ar_valid, o_r_ready all 0; o_data, o_word_index, o_ar_addr all 0.
- Reset asserted mid-burst: the FSM returns to IDLE immediately, and outputs take their reset values asynchronously. Further R beats are ignored because o_r_ready=0.
- Cycle schedule:
  - start sampled at edge 0;
  - o_ar_valid high from cycle 1;
  - with i_ar_ready=1, DATA begins in cycle 2;
  - each beat handshaken in cycle n appears on o_data/o_data_valid in cycle n+1.
- Minimum latency, start to o_read_last: BLOCK_WORDS+2 cycles (18 with defaults, zero wait states).
- i_r_valid gaps stall delivery only. o_data_valid is never asserted without a handshake in the previous cycle.
- A new i_start_read is accepted in the cycle following o_read_last, at the earliest.

## Structure
- Shared package `axi_pkg` holds:
  - the state enum `t_rd_state` (IDLE, ADDR, DATA);
  - constants AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
- Single flat module. The beat counter and error detection are small and stay inline; no sub-module is warranted.

## Test plan
- Zero-wait refill: start with i_addr=0x1000_0004, ready/valid held high. Required: o_ar_addr=0x1000_0000, o_ar_len=15, o_ar_size=2, o_ar_burst=1; 16 words with indices 0..15; o_read_last in cycle 18 with index 15; o_resp_error=0.
- AR backpressure plus R gaps: i_ar_ready held low for 5 cycles, i_r_valid toggled every other cycle. Required: address stays stable throughout; exactly 16 o_data_valid pulses, in order; o_read_last only on the last pulse.
- SLVERR on beat 7: the burst still completes with 16 words, o_resp_error=1 from beat 7 onward, and it is cleared by the next start.
- Protocol error: i_r_last=1 on beat 3. Required: o_resp_error=1, the master continues to 16 beats, o_read_last on beat 15 only.
- Busy rejection and reset: i_start_read pulsed during DATA produces no second AR. Asserting arst at beat 5 returns all outputs to their reset values immediately, and a fresh start afterwards completes normally.
